exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_pkg.sv | 49 ++++
 rtl/exec_ctrl_if.sv | 36 +++
 rtl/instr_decode.sv | 59 +++++
 rtl/exec_ctrl.sv | 107 ++++++++++
 tb/tb_exec_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execution controller: opcodes, FSM states,
// decoded-control bundle and default widths.
package exec_pkg;

    localparam int PC_W_DEF = 10;
    localparam int IR_W_DEF = 9;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADC  = 4'h1,
        OP_SUB  = 4'h2,
        OP_MOVE = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_ADDI = 4'h7,
        OP_BNE  = 4'h8,
        OP_BEQ  = 4'h9,
        OP_MOVI = 4'hA,
        OP_CLC  = 4'hB,
        OP_RSV  = 4'hC,
        OP_CMP  = 4'hD,
        OP_HALT = 4'hE,
        OP_NOP  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_e;

    typedef struct packed {
        logic       a_sel;
        logic       b_sel;
        logic [2:0] rf_raddr;
        logic [2:0] rf_waddr;
        logic       rf_we;
        logic       ld_carry;
        logic       clr_carry;
        logic       ld_eq;
        logic       is_beq;
        logic       is_bne;
        logic       is_halt;
        logic [4:0] lut_idx;
    } dec_t;

endpackage

// File: rtl/exec_ctrl_if.sv
// Controller <-> datapath bus: instruction fetch, branch LUT, ALU and
// register-file controls. master = controller, slave = datapath/memories.
interface exec_ctrl_if
    import exec_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int IR_W = IR_W_DEF
);
    logic [PC_W-1:0] pc;
    logic [IR_W-1:0] instr;
    logic [4:0]      lut_idx;
    logic [PC_W-1:0] lut_target;
    logic [3:0]      alu_cmd;
    logic            a_sel;
    logic            b_sel;
    logic [7:0]      imm;
    logic [2:0]      rf_raddr;
    logic [2:0]      rf_waddr;
    logic            rf_we;
    logic            sc_i;
    logic            sc_o;
    logic            equal;

    modport master (
        output pc, lut_idx, alu_cmd, a_sel, b_sel, imm,
        output rf_raddr, rf_waddr, rf_we, sc_i,
        input  instr, lut_target, sc_o, equal
    );

    modport slave (
        input  pc, lut_idx, alu_cmd, a_sel, b_sel, imm,
        input  rf_raddr, rf_waddr, rf_we, sc_i,
        output instr, lut_target, sc_o, equal
    );

endinterface

// File: rtl/instr_decode.sv
// Combinational decode of the latched instruction into controls.
// Ports: ir (opcode[8:5], field F[4:0]) -> dec (dec_t bundle).
module instr_decode
    import exec_pkg::*;
(
    input  logic [8:0] ir,
    output dec_t       dec
);

    opcode_e    op;
    logic [4:0] f;

    assign op = opcode_e'(ir[8:5]);
    assign f  = ir[4:0];

    always_comb begin
        dec = '0;
        unique case (op)
            OP_ADD, OP_ADC, OP_SUB: begin
                dec.rf_raddr = f[2:0];
                dec.rf_we    = 1'b1;
                dec.ld_carry = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                dec.rf_raddr = f[2:0];
                dec.rf_we    = 1'b1;
            end
            OP_MOVE: begin
                dec.rf_waddr = f[2:0];
                dec.rf_we    = 1'b1;
            end
            OP_ADDI: begin
                dec.b_sel    = 1'b1;
                dec.rf_we    = 1'b1;
                dec.ld_carry = 1'b1;
            end
            OP_MOVI: begin
                dec.a_sel = 1'b1;
                dec.rf_we = 1'b1;
            end
            OP_CLC:  dec.clr_carry = 1'b1;
            OP_CMP: begin
                dec.rf_raddr = f[2:0];
                dec.ld_eq    = 1'b1;
            end
            OP_BEQ: begin
                dec.is_beq  = 1'b1;
                dec.lut_idx = f;
            end
            OP_BNE: begin
                dec.is_bne  = 1'b1;
                dec.lut_idx = f;
            end
            OP_HALT: dec.is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// Two-cycle (FETCH/EXEC) instruction sequencer with carry/eq flags.
// Ports: clk, reset_n (sync), start, bus (master), busy, done.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int IR_W = IR_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    exec_ctrl_if.master  bus,
    output logic         busy,
    output logic         done
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            carry_q, carry_d;
    logic            eq_q, eq_d;
    logic            in_exec;
    logic            taken;
    dec_t            dec;

    instr_decode u_dec (
        .ir  (ir_q[8:0]),
        .dec (dec)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
        end
    end

    assign taken = (dec.is_beq & eq_q) | (dec.is_bne & ~eq_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        eq_d    = eq_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    carry_d = 1'b0;
                    eq_d    = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = bus.instr;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (dec.is_halt) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = taken ? bus.lut_target
                                    : pc_q + PC_W'(1);
                end
                if (dec.ld_carry)  carry_d = bus.sc_o;
                if (dec.clr_carry) carry_d = 1'b0;
                if (dec.ld_eq)     eq_d    = bus.equal;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controls are only live in EXEC; a reset arriving during EXEC
    // kills the write in the same cycle, before the edge lands.
    assign in_exec      = (state_q == S_EXEC);
    assign bus.pc       = pc_q;
    assign bus.alu_cmd  = in_exec ? ir_q[8:5] : 4'd0;
    assign bus.a_sel    = in_exec & dec.a_sel;
    assign bus.b_sel    = in_exec & dec.b_sel;
    assign bus.imm      = in_exec ? {3'd0, ir_q[4:0]} : 8'd0;
    assign bus.rf_raddr = in_exec ? dec.rf_raddr : 3'd0;
    assign bus.rf_waddr = in_exec ? dec.rf_waddr : 3'd0;
    assign bus.rf_we    = in_exec & dec.rf_we & reset_n;
    assign bus.lut_idx  = in_exec ? dec.lut_idx : 5'd0;
    assign bus.sc_i     = carry_q;

    assign busy = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: decode vector table, directed
// corner sequences and a random program against an instruction-level model.
module tb_exec_ctrl;
    import exec_pkg::*;

    localparam int PW = 10;
    localparam int IW = 9;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic busy, done;
    logic sc_o_drv = 1'b0;
    logic eq_drv   = 1'b0;

    logic [8:0]    mem [1024];
    logic [PW-1:0] lut [32];

    exec_ctrl_if #(.PC_W(PW), .IR_W(IW)) bus ();

    assign bus.instr      = mem[bus.pc];
    assign bus.lut_target = lut[bus.lut_idx];
    assign bus.sc_o       = sc_o_drv;
    assign bus.equal      = eq_drv;

    exec_ctrl #(.PC_W(PW), .IR_W(IW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [PW-1:0] m_pc;
    bit            m_carry;
    bit            m_eq;

    typedef struct {
        logic [3:0]    op;
        logic [4:0]    f;
        bit            eq;
        bit            sc;
        bit            we;
        logic [2:0]    waddr;
        logic [PW-1:0] pc_nxt;
        bit            carry;
        bit            dn;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit writes(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                          4'h5, 4'h6, 4'h7, 4'hA};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        tick();
        tick();
        chk("rst_pc", 32'(bus.pc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_we", 32'(bus.rf_we), 0);
        chk("rst_sci", 32'(bus.sc_i), 0);
        reset_n = 1'b1;
        start   = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_alu", 32'(bus.alu_cmd), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start   = 1'b0;
        m_pc    = '0;
        m_carry = 1'b0;
        m_eq    = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_pc", 32'(bus.pc), 0);
    endtask

    // Entered at FETCH; runs one instruction (two cycles).
    task automatic step(input bit sc, input bit eq, input bit noise,
                        output bit halted, output bit we,
                        output logic [2:0] wa);
        logic [8:0] ir;
        logic [3:0] op;
        logic [4:0] f;
        chk("fetch_busy", 32'(busy), 1);
        chk("fetch_done", 32'(done), 0);
        chk("fetch_pc", 32'(bus.pc), 32'(m_pc));
        chk("fetch_we", 32'(bus.rf_we), 0);
        ir = mem[m_pc];
        op = ir[8:5];
        f  = ir[4:0];
        start = noise;
        tick();
        sc_o_drv = sc;
        eq_drv   = eq;
        chk("exec_busy", 32'(busy), 1);
        chk("alu_cmd", 32'(bus.alu_cmd), 32'(op));
        chk("imm", 32'(bus.imm), 32'(f));
        chk("sc_i", 32'(bus.sc_i), 32'(m_carry));
        chk("rf_we", 32'(bus.rf_we), 32'(writes(op)));
        if (writes(op)) begin
            chk("rf_waddr", 32'(bus.rf_waddr),
                op == 4'h3 ? 32'(f[2:0]) : 0);
            chk("a_sel", 32'(bus.a_sel), 32'(op == 4'hA));
            chk("b_sel", 32'(bus.b_sel), 32'(op == 4'h7));
        end
        if (op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'hD})
            chk("rf_raddr", 32'(bus.rf_raddr), 32'(f[2:0]));
        if (op inside {4'h8, 4'h9})
            chk("lut_idx", 32'(bus.lut_idx), 32'(f));
        we     = bus.rf_we;
        wa     = bus.rf_waddr;
        halted = (op == 4'hE);
        if (!halted) begin
            if ((op == 4'h9 && m_eq) || (op == 4'h8 && !m_eq))
                m_pc = lut[f];
            else
                m_pc = m_pc + PW'(1);
        end
        if (op inside {4'h0, 4'h1, 4'h2, 4'h7}) m_carry = sc;
        if (op == 4'hB) m_carry = 1'b0;
        if (op == 4'hD) m_eq = eq;
        tick();
        start = 1'b0;
        if (halted) begin
            chk("halt_done", 32'(done), 1);
            chk("halt_busy", 32'(busy), 0);
            chk("halt_pc", 32'(bus.pc), 32'(m_pc));
        end
    endtask

    initial begin
        bit         h, we;
        logic [2:0] wa;

        for (int i = 0; i < 1024; i++) mem[i] = {4'hE, 5'd0};
        for (int i = 0; i < 32; i++)   lut[i] = PW'(10'h100 + i);

        //        op     f     eq sc we wa   pc_nxt  cy dn
        vecs[0]  = '{4'h0, 5'd5, 0, 0, 1, 3'd0, 10'd3, 0, 0};
        vecs[1]  = '{4'h2, 5'd5, 0, 1, 1, 3'd0, 10'd3, 1, 0};
        vecs[2]  = '{4'h4, 5'd5, 1, 0, 1, 3'd0, 10'd3, 1, 0};
        vecs[3]  = '{4'h3, 5'd6, 0, 0, 1, 3'd6, 10'd3, 1, 0};
        vecs[4]  = '{4'h7, 5'd5, 0, 0, 1, 3'd0, 10'd3, 0, 0};
        vecs[5]  = '{4'hA, 5'd5, 0, 0, 1, 3'd0, 10'd3, 1, 0};
        vecs[6]  = '{4'hB, 5'd5, 0, 1, 0, 3'd0, 10'd3, 0, 0};
        vecs[7]  = '{4'h9, 5'd5, 1, 0, 0, 3'd0, 10'h105, 1, 0};
        vecs[8]  = '{4'h9, 5'd5, 0, 0, 0, 3'd0, 10'd3, 1, 0};
        vecs[9]  = '{4'h8, 5'd5, 0, 0, 0, 3'd0, 10'h105, 1, 0};
        vecs[10] = '{4'h8, 5'd5, 1, 0, 0, 3'd0, 10'd3, 1, 0};
        vecs[11] = '{4'hC, 5'd5, 0, 1, 0, 3'd0, 10'd3, 1, 0};
        vecs[12] = '{4'hF, 5'd5, 0, 0, 0, 3'd0, 10'd3, 1, 0};
        vecs[13] = '{4'hE, 5'd5, 0, 0, 0, 3'd0, 10'd2, 1, 1};
        vecs[14] = '{4'hD, 5'd5, 1, 0, 0, 3'd0, 10'd3, 1, 0};

        // Reset held two cycles with start high
        do_reset();

        // Decode table: addi (carry=1), cmp (eq), then the vector op
        for (int v = 0; v < 15; v++) begin
            mem[0] = {4'h7, 5'd0};
            mem[1] = {4'hD, 5'd0};
            mem[2] = {vecs[v].op, vecs[v].f};
            mem[3] = {4'hE, 5'd0};
            do_reset();
            do_start();
            step(1'b1, 1'b0, 1'b0, h, we, wa);
            step(1'b0, vecs[v].eq, 1'b0, h, we, wa);
            step(vecs[v].sc, vecs[v].eq, 1'b0, h, we, wa);
            chk("vec_we", 32'(we), 32'(vecs[v].we));
            chk("vec_waddr", 32'(wa), 32'(vecs[v].waddr));
            chk("vec_pc", 32'(bus.pc), 32'(vecs[v].pc_nxt));
            chk("vec_carry", 32'(bus.sc_i), 32'(vecs[v].carry));
            chk("vec_done", 32'(done), 32'(vecs[v].dn));
        end

        // movi 5; add r1 (carry out 1); halt
        do_reset();
        mem[0] = {4'hA, 5'd5};
        mem[1] = {4'h0, 5'd1};
        mem[2] = {4'hE, 5'd0};
        do_start();
        step(1'b0, 1'b0, 1'b0, h, we, wa);
        chk("p_movi_we", 32'(we), 1);
        step(1'b1, 1'b0, 1'b0, h, we, wa);
        chk("p_add_we", 32'(we), 1);
        chk("p_add_carry", 32'(bus.sc_i), 1);
        step(1'b0, 1'b0, 1'b0, h, we, wa);
        chk("p_done", 32'(done), 1);
        chk("p_pc", 32'(bus.pc), 2);

        // cmp equal=1; beq F=3 -> 0x2A0; then the same with bne
        mem[0] = {4'hD, 5'd0};
        mem[1] = {4'h9, 5'd3};
        lut[3] = 10'h2A0;
        mem[10'h2A0] = {4'hE, 5'd0};
        do_start();
        step(1'b0, 1'b1, 1'b0, h, we, wa);
        step(1'b0, 1'b0, 1'b0, h, we, wa);
        chk("beq_pc", 32'(bus.pc), 32'h2A0);
        step(1'b0, 1'b0, 1'b0, h, we, wa);
        mem[1] = {4'h8, 5'd3};
        do_start();
        step(1'b0, 1'b1, 1'b0, h, we, wa);
        step(1'b0, 1'b0, 1'b0, h, we, wa);
        chk("bne_pc", 32'(bus.pc), 2);
        step(1'b0, 1'b0, 1'b0, h, we, wa);

        // Jump to 1023, nop there wraps pc to 0
        mem[0] = {4'h8, 5'd1};
        lut[1] = 10'd1023;
        mem[1023] = {4'hF, 5'd0};
        do_start();
        step(1'b0, 1'b0, 1'b0, h, we, wa);
        chk("jmp_pc", 32'(bus.pc), 1023);
        step(1'b0, 1'b0, 1'b0, h, we, wa);
        chk("wrap_we", 32'(we), 0);
        chk("wrap_pc", 32'(bus.pc), 0);

        // Reset during EXEC of add: no write, carry cleared, IDLE
        do_reset();
        mem[0] = {4'h7, 5'd1};
        mem[1] = {4'h0, 5'd1};
        do_start();
        step(1'b1, 1'b0, 1'b0, h, we, wa);
        chk("pre_carry", 32'(bus.sc_i), 1);
        tick();
        sc_o_drv = 1'b1;
        chk("exec_we_live", 32'(bus.rf_we), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_exec_we", 32'(bus.rf_we), 0);
        tick();
        chk("rst_exec_carry", 32'(bus.sc_i), 0);
        chk("rst_exec_busy", 32'(busy), 0);
        chk("rst_exec_pc", 32'(bus.pc), 0);
        reset_n = 1'b1;
        tick();
        chk("rst_exec_idle", 32'(busy), 0);
        chk("rst_exec_done", 32'(done), 0);

        // Random programs, start noise in FETCH/EXEC, restart from DONE
        for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);
        for (int i = 0; i < 32; i++)   lut[i] = PW'($urandom);
        do_start();
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) == 0, h, we, wa);
            if (h) begin
                tick();
                tick();
                chk("done_hold", 32'(done), 1);
                chk("done_pc", 32'(bus.pc), 32'(m_pc));
                chk("done_we", 32'(bus.rf_we), 0);
                do_start();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
